// File: rtl/sar_adc_controller_if.sv
// Signal bundle between the SAR controller and its environment: DAC, comparator and result consumer.
// The controller side uses the master modport, and the environment or bench uses the slave modport.
interface sar_adc_controller_if #(
    parameter int WIDTH = 10
);
    // Handshake: a result moves on a rising edge where result_valid and
    // result_ready are both 1. Once result_valid is raised, result and
    // dac_code stay stable until that edge. start is sampled only in IDLE.
    logic             start;
    logic             comparator_out;
    logic [WIDTH-1:0] dac_code;
    logic             busy;
    logic [WIDTH-1:0] result;
    logic             result_valid;
    logic             result_ready;

    modport master (
        input  start, comparator_out, result_ready,
        output dac_code, busy, result, result_valid
    );

    modport slave (
        output start, comparator_out, result_ready,
        input  dac_code, busy, result, result_valid
    );
endinterface

// File: rtl/sar_adc_controller.sv
// Successive-approximation ADC controller. It resolves one bit per (SETTLE_CYCLES+1) clocks, MSB first,
// then holds the result until the consumer accepts it.
module sar_adc_controller #(
    parameter int WIDTH         = 10,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    sar_adc_controller_if.master      bus,
    output logic [1:0]                o_state
);
    localparam int                BW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BW-1:0]     TOP_BIT  = BW'(WIDTH - 1);
    localparam logic [3:0]        SETTLE   = 4'(SETTLE_CYCLES);
    localparam logic [WIDTH-1:0]  MSB_ONLY = WIDTH'(1) << (WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [3:0]       r_cnt, w_cnt_nxt;
    logic [BW-1:0]    r_bit, w_bit_nxt;
    logic [WIDTH-1:0] r_code, w_code_nxt;
    logic [WIDTH-1:0] r_result, w_result_nxt;
    logic [WIDTH-1:0] w_code_dec;

    // Code after resolving the current bit: keep or drop the trial bit,
    // then raise the next lower bit as the new trial.
    always_comb begin
        w_code_dec        = r_code;
        w_code_dec[r_bit] = bus.comparator_out;
        if (r_bit != '0) begin
            w_code_dec[r_bit - BW'(1)] = 1'b1;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_bit_nxt    = r_bit;
        w_code_nxt   = r_code;
        w_result_nxt = r_result;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_state_nxt = CONV;
                    w_bit_nxt   = TOP_BIT;
                    w_cnt_nxt   = SETTLE;
                    w_code_nxt  = MSB_ONLY;
                end
            end
            CONV: begin
                if (r_cnt != 4'd0) begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end else begin
                    w_code_nxt = w_code_dec;
                    if (r_bit != '0) begin
                        w_bit_nxt = r_bit - BW'(1);
                        w_cnt_nxt = SETTLE;
                    end else begin
                        w_state_nxt  = HOLD;
                        w_result_nxt = w_code_dec;
                    end
                end
            end
            HOLD: begin
                if (bus.result_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_cnt    <= 4'd0;
            r_bit    <= TOP_BIT;
            r_code   <= '0;
            r_result <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_bit    <= w_bit_nxt;
            r_code   <= w_code_nxt;
            r_result <= w_result_nxt;
        end
    end

    assign bus.dac_code     = r_code;
    assign bus.result       = r_result;
    assign bus.busy         = (r_state == CONV);
    assign bus.result_valid = (r_state == HOLD);
    assign o_state          = r_state;
endmodule

// File: doc/sar_adc_controller.md
SAR_ADC_CONTROLLER -- requirements
Module: sar_adc_controller

Interface
REQ-001 Parameter WIDTH, default 10: conversion resolution in bits; also the width of the DAC code.
REQ-002 Parameter SETTLE_CYCLES, default 2: extra wait cycles per bit so the DAC and comparator can settle before the comparator is sampled; legal range 0..15.
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset (asserted when 0), sampled on rising edge of clk.
REQ-005 start  input  1  conversion request; accepted only in IDLE.
REQ-006 comparator_out  input  1  1 = analog input >= DAC output for the current trial code; 0 = below.
REQ-007 dac_code  output  WIDTH  trial code driven to the digital_to_analog_converter input_voltage_digital port.
REQ-008 busy  output  1  high while a conversion is in progress (CONV state).
REQ-009 result  output  WIDTH  final converted code; valid only while result_valid=1.
REQ-010 result_valid  output  1  result available; held until accepted.
REQ-011 result_ready  input  1  consumer accepts result when result_valid=1 and result_ready=1 on a rising edge.

Function
REQ-012 The block SHALL implement a three-state FSM: IDLE, CONV, HOLD.
REQ-013 IDLE: start=1 on an edge -> CONV; bit index b=WIDTH-1; settle counter cnt=SETTLE_CYCLES; working code = only bit WIDTH-1 set; dac_code = working code (0x200 for WIDTH=10).
REQ-014 CONV, cnt>0: cnt decrements; dac_code and working code are unchanged; comparator_out is ignored.
REQ-015 CONV, cnt=0: the block samples comparator_out; bit b of the working code keeps the trial 1 if comparator_out=1 and is cleared otherwise.
REQ-016 CONV decision with b>0: b decrements; bit b-1 is set as the new trial bit; cnt reloads SETTLE_CYCLES; dac_code updates on the same edge.
REQ-017 CONV decision with b=0: the FSM enters HOLD; result and dac_code = final working code; result_valid=1.
REQ-018 Latency: result_valid SHALL rise exactly WIDTH*(SETTLE_CYCLES+1) rising edges after the edge that accepted start (30 for the defaults).
REQ-019 busy=1 exactly while in CONV; it is 0 in IDLE and HOLD.
REQ-020 HOLD: result, dac_code and result_valid are stable until result_ready=1; on that edge -> IDLE, result_valid=0, and result keeps its value.
REQ-021 start is ignored in CONV and HOLD (no queuing); start in the same cycle as the HOLD->IDLE handshake is ignored.
REQ-022 With start held high continuously, back-to-back conversions SHALL be separated by exactly one IDLE cycle.
REQ-023 comparator_out values sampled when cnt>0 or outside CONV SHALL have no effect on any output.
REQ-024 dac_code SHALL only change on trial-bit updates, conversion start, and reset; it SHALL never glitch within a settle window.
REQ-025 All arithmetic is unsigned; the counter is 4 bits wide; b is ceil(log2(WIDTH)) bits wide; no wrap-around occurs for legal parameter values.

Reset
REQ-026 reset=0 on an edge forces IDLE, dac_code=0, result=0, result_valid=0, busy=0, cnt=0, b=WIDTH-1, regardless of state.
REQ-027 Reset asserted mid-conversion or in HOLD SHALL discard the partial or pending result with no handshake.
REQ-028 reset has priority over start and result_ready in the same cycle.

Verification
REQ-029 Ideal comparator model, Vin code 0x2A5, defaults, start pulse -> result=0x2A5, result_valid high 30 edges after acceptance, dac_code trial sequence 0x200, 0x300, 0x280, 0x2C0, 0x2A0, ...
REQ-030 comparator_out tied 1 -> result=0x3FF; comparator_out tied 0 -> result=0x000; SETTLE_CYCLES=0 -> result_valid high after 10 edges.
REQ-031 comparator_out toggled randomly during settle cycles and held correct at the cnt=0 cycles -> result equals the Vin code (REQ-023).
REQ-032 result_ready low for 5 cycles after result_valid, start pulsed during HOLD -> result_valid and result stable throughout, no new conversion starts, IDLE entered on the ready edge.
REQ-033 reset=0 asserted 12 cycles into a conversion -> all outputs 0 on the next edge; a fresh start afterwards converts correctly.
REQ-034 start held high, result_ready tied high -> repeated conversions, each 30-edge CONV window separated by one IDLE cycle, busy low only in the HOLD and IDLE cycles.
